// File: rtl/input_debouncer.sv
// Raw switch/button conditioner: two-flop synchroniser, then a consecutive-sample
// stability filter that drives a clean level plus a one-cycle strobe per accepted change.
module input_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic data_o,
    output logic en_o,
    output logic rise_o,
    output logic fall_o,
    output logic busy_o
);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce_cycles
        $error("input_debouncer: DEBOUNCE_CYCLES must be in 2..65535");
    end

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s1_q, s2_q;
    logic             data_d, rise_d, fall_d;

    // raw_i is asynchronous; only s2_q may be observed by the filter.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= raw_i;
            s2_q <= s1_q;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_o;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            STABLE: begin
                if (s2_q != data_o) begin
                    state_d = PENDING;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            PENDING: begin
                if (s2_q == data_o) begin
                    // Glitch ended before qualification: discard it silently.
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    data_d  = s2_q;
                    rise_d  = s2_q;
                    fall_d  = ~s2_q;
                    state_d = STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            data_o  <= 1'b0;
            en_o    <= 1'b0;
            rise_o  <= 1'b0;
            fall_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_o  <= data_d;
            en_o    <= rise_d | fall_d;
            rise_o  <= rise_d;
            fall_o  <= fall_d;
        end
    end

    assign busy_o = (state_q == PENDING);

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer with DEBOUNCE_CYCLES=4: directed vector
// table, reset corner sequences and randomized raw input against a run-length model.
module tb_input_debouncer;

    localparam int DC = 4;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    logic raw_i  = 1'b0;
    logic data_o, en_o, rise_o, fall_o, busy_o;

    int checks = 0;
    int errors = 0;

    input_debouncer #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .raw_i  (raw_i),
        .data_o (data_o),
        .en_o   (en_o),
        .rise_o (rise_o),
        .fall_o (fall_o),
        .busy_o (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: the input is seen two edges late; a change is accepted once the
    // seen value has disagreed with the output for DC consecutive edges.
    logic m_s1 = 1'b0, m_s2 = 1'b0;
    logic m_data = 1'b0, m_en = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
    int   m_run = 0;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_s1 <= 1'b0; m_s2 <= 1'b0; m_data <= 1'b0;
            m_en <= 1'b0; m_rise <= 1'b0; m_fall <= 1'b0; m_run <= 0;
        end else begin
            m_s1   <= raw_i;
            m_s2   <= m_s1;
            m_en   <= 1'b0;
            m_rise <= 1'b0;
            m_fall <= 1'b0;
            if (m_s2 == m_data) begin
                m_run <= 0;
            end else if (m_run + 1 >= DC) begin
                m_run  <= 0;
                m_data <= m_s2;
                m_en   <= 1'b1;
                m_rise <= m_s2;
                m_fall <= ~m_s2;
            end else begin
                m_run <= m_run + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    function automatic logic [4:0] outs();
        return {data_o, en_o, rise_o, fall_o, busy_o};
    endfunction

    typedef struct {
        logic       raw;
        logic [4:0] exp;  // {data, en, rise, fall, busy} after the edge
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic raw, input logic [4:0] exp);
        vec_t v;
        v.raw = raw;
        v.exp = exp;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [4:0] rst_seq [7];
        int         rises;
        int         hold;

        // Clean rise, clean fall, bounce rejection, bounce then settle.
        add(1, 5'b00000); add(1, 5'b00000); add(1, 5'b00001); add(1, 5'b00001);
        add(1, 5'b00001); add(1, 5'b11100); add(1, 5'b10000);
        add(0, 5'b10000); add(0, 5'b10000); add(0, 5'b10001); add(0, 5'b10001);
        add(0, 5'b10001); add(0, 5'b01010); add(0, 5'b00000);
        add(1, 5'b00000); add(1, 5'b00000); add(1, 5'b00001); add(0, 5'b00001);
        add(1, 5'b00001); add(1, 5'b00000); add(0, 5'b00001); add(0, 5'b00001);
        add(0, 5'b00000); add(0, 5'b00000);
        add(1, 5'b00000); add(1, 5'b00000); add(0, 5'b00001); add(1, 5'b00001);
        add(1, 5'b00000); add(1, 5'b00001); add(1, 5'b00001); add(1, 5'b00001);
        add(1, 5'b11100); add(1, 5'b10000); add(1, 5'b10000);

        rst_seq = '{5'b00000, 5'b00000, 5'b00001, 5'b00001, 5'b00001, 5'b11100, 5'b10000};

        // Reset held with raw toggling.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            check("reset_hold", outs(), 5'b00000);
            raw_i = ~raw_i;
        end
        raw_i  = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            check("reset_release_idle", outs(), 5'b00000);
        end

        // Directed vector table.
        foreach (vecs[i]) begin
            raw_i = vecs[i].raw;
            @(negedge clk_i);
            check($sformatf("vec[%0d]", i), outs(), vecs[i].exp);
        end

        // Asynchronous clear while data_o is high.
        raw_i  = 1'b0;
        rst_ni = 1'b0;
        #1;
        check("async_clear_data", outs(), 5'b00000);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (4) @(negedge clk_i);
        check("idle_after_clear", outs(), 5'b00000);

        // Reset mid-qualification (busy with cnt=2), then full-latency rise after release.
        raw_i = 1'b1;
        repeat (4) @(negedge clk_i);
        check("busy_before_reset", outs(), 5'b00001);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_clear_busy", outs(), 5'b00000);
        @(negedge clk_i);
        check("reset_across_edge", outs(), 5'b00000);
        rst_ni = 1'b1;
        rises  = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk_i);
            rises += int'(rise_o);
            check($sformatf("post_reset_rise[%0d]", i), outs(), rst_seq[i]);
        end
        check("post_reset_rise_count", rises, 1);

        // Randomized raw input against the model, with occasional resets.
        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk_i);
            check("random_vs_model", outs(), {m_data, m_en, m_rise, m_fall, m_run != 0});
            if (!rst_ni) begin
                rst_ni = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                rst_ni = 1'b0;
            end
            if (hold == 0) begin
                raw_i = 1'($urandom_range(0, 1));
                hold  = $urandom_range(1, 8);
            end
            hold--;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
